bcd_stopwatch_ctrl: RTL and testbench

BCD_STOPWATCH_CTRL -- requirements
Module: bcd_stopwatch_ctrl

---
 rtl/bcd_stopwatch_ctrl_pkg.sv | 17 +
 rtl/bcd_stopwatch_ctrl_decade_digit.sv | 29 ++
 rtl/bcd_stopwatch_ctrl.sv | 105 ++++++++++
 tb/tb_bcd_stopwatch_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_stopwatch_ctrl_pkg.sv
// Shared definitions for the BCD stopwatch: FSM state encoding and decade digit constants.
package bcd_stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  function automatic logic [BCD_W-1:0] bcd_next(input logic [BCD_W-1:0] d);
    return (d == BCD_MAX) ? '0 : d + 1'b1;
  endfunction

endpackage

// File: rtl/bcd_stopwatch_ctrl_decade_digit.sv
// Single mod-10 counter digit; carry tells the next digit to advance on this edge.
module decade_digit
  import bcd_stopwatch_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  logic [BCD_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)      q_d = '0;
    else if (inc) q_d = bcd_next(q_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q     = q_q;
  assign carry = inc & (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// BCD stopwatch: IDLE/RUN/PAUSE control, tick prescaler, cascaded decade digits and lap capture.
module bcd_stopwatch_ctrl
  import bcd_stopwatch_ctrl_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   digits,
  output logic [4*DIGITS-1:0]   lap_digits,
  output logic                  lap_valid,
  output logic                  rollover,
  output logic [1:0]            state
);

  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

  state_e              state_q, state_d;
  logic [15:0]         presc_q, presc_d;
  logic [4*DIGITS-1:0] lap_digits_q, lap_digits_d;
  logic                lap_valid_q, lap_valid_d;
  logic                rollover_q, rollover_d;
  logic [4*DIGITS-1:0] count;
  logic [DIGITS:0]     inc_chain;
  logic                is_idle, is_run, tick, lap_fire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_RUN;
        ST_RUN:   if (stop)  state_d = ST_PAUSE;
        ST_PAUSE: if (start) state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    is_idle = (state_q == ST_IDLE);
    is_run  = (state_q == ST_RUN);
    state   = state_q;
  end

  // The prescaler advances in every RUN cycle, including the one that samples stop.
  always_comb begin
    tick    = is_run && (presc_q == PRESC_LAST);
    presc_d = presc_q;
    if (clear || is_idle) presc_d = '0;
    else if (is_run)      presc_d = tick ? '0 : presc_q + 16'd1;
  end

  assign inc_chain[0] = tick;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    decade_digit u_digit (
      .clk   (clk),
      .reset (reset),
      .clr   (clear),
      .inc   (inc_chain[k]),
      .q     (count[4*k +: 4]),
      .carry (inc_chain[k+1])
    );
  end

  // Lap captures the pre-edge count; it is meaningless in IDLE and loses to clear.
  always_comb begin
    lap_fire     = lap && !clear && !is_idle;
    lap_valid_d  = lap_fire;
    lap_digits_d = lap_fire ? count : lap_digits_q;
    rollover_d   = inc_chain[DIGITS] && !clear;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q      <= '0;
      lap_digits_q <= '0;
      lap_valid_q  <= 1'b0;
      rollover_q   <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      lap_digits_q <= lap_digits_d;
      lap_valid_q  <= lap_valid_d;
      rollover_q   <= rollover_d;
    end
  end

  assign digits     = count;
  assign lap_digits = lap_digits_q;
  assign lap_valid  = lap_valid_q;
  assign rollover   = rollover_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl: directed scenarios plus random commands against an integer model.
module tb_bcd_stopwatch_ctrl;

  localparam int TD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, stop, clear, lap;
  logic [7:0] digits, lap_digits;
  logic       lap_valid, rollover;
  logic [1:0] state;

  logic       start1, stop1, clear1, lap1;
  logic [7:0] digits1, lap_digits1;
  logic       lap_valid1, rollover1;
  logic [1:0] state1;

  bcd_stopwatch_ctrl #(.DIGITS(2), .TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .digits(digits), .lap_digits(lap_digits), .lap_valid(lap_valid),
    .rollover(rollover), .state(state)
  );

  bcd_stopwatch_ctrl #(.DIGITS(2), .TICK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .stop(stop1), .clear(clear1), .lap(lap1),
    .digits(digits1), .lap_digits(lap_digits1), .lap_valid(lap_valid1),
    .rollover(rollover1), .state(state1)
  );

  int tests_run = 0;
  int fails = 0;

  // Reference model: count as an integer 0..99, state 0=IDLE 1=RUN 2=PAUSE.
  int m_state, m_cnt, m_pre, m_lap;
  bit m_lapv, m_roll;

  function automatic logic [7:0] bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_pre = 0; m_lap = 0; m_lapv = 0; m_roll = 0;
  endtask

  task automatic model_edge();
    bit tk, fire;
    tk   = (m_state == 1) && (m_pre == TD - 1);
    fire = lap && !clear && (m_state != 0);
    m_lapv = fire;
    if (fire) m_lap = m_cnt;
    m_roll = !clear && tk && (m_cnt == 99);
    if (clear)   m_cnt = 0;
    else if (tk) m_cnt = (m_cnt + 1) % 100;
    if (clear || m_state == 0) m_pre = 0;
    else if (m_state == 1)     m_pre = (m_pre + 1) % TD;
    if (clear)                       m_state = 0;
    else if (m_state == 0 && start)  m_state = 1;
    else if (m_state == 1 && stop)   m_state = 2;
    else if (m_state == 2 && start)  m_state = 1;
  endtask

  task automatic step(input logic s, input logic p, input logic c, input logic l);
    start = s; stop = p; clear = c; lap = l;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    {start, stop, clear, lap} = 4'b0;
    {start1, stop1, clear1, lap1} = 4'b0;
    model_reset();
    #2;
    tests_run++;
    if ({state, digits, lap_digits, lap_valid, rollover} !== 20'h0) begin
      fails++; $display("FAIL reset_outputs got %h required 0", {state, digits, lap_digits, lap_valid, rollover});
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    step(0, 0, 0, 0);
    tests_run++;
    if (state !== 2'b00 || digits !== 8'h00) begin
      fails++; $display("FAIL reset_release got state %b digits %h required 00/00", state, digits);
    end
  endtask

  task automatic test_start_count();
    step(1, 0, 0, 0);
    tests_run++;
    if (state !== 2'b01) begin fails++; $display("FAIL start_state got %b required 01", state); end
    repeat (2) step(0, 0, 0, 0);
    tests_run++;
    if (digits !== 8'h01) begin fails++; $display("FAIL first_tick got %h required 01", digits); end
    repeat (18) step(0, 0, 0, 0);
    tests_run++;
    if (digits !== 8'h10) begin fails++; $display("FAIL twenty_cycles got %h required 10", digits); end
    tests_run++;
    if (digits !== bcd(m_cnt)) begin fails++; $display("FAIL start_model got %h required %h", digits, bcd(m_cnt)); end
  endtask

  task automatic test_rollover();
    int n;
    n = 0;
    while (digits !== 8'h99 && n < 400) begin step(0, 0, 0, 0); n++; end
    tests_run++;
    if (digits !== 8'h99) begin fails++; $display("FAIL reach_99 got %h required 99", digits); end
    step(0, 0, 0, 0);
    tests_run++;
    if (digits !== 8'h99 || rollover !== 1'b0) begin
      fails++; $display("FAIL pre_wrap got %h/%b required 99/0", digits, rollover);
    end
    step(0, 0, 0, 0);
    tests_run++;
    if (digits !== 8'h00 || rollover !== 1'b1 || state !== 2'b01) begin
      fails++; $display("FAIL wrap got %h/%b/%b required 00/1/01", digits, rollover, state);
    end
    step(0, 0, 0, 0);
    tests_run++;
    if (rollover !== 1'b0) begin fails++; $display("FAIL rollover_width got %b required 0", rollover); end
  endtask

  task automatic test_pause();
    int n;
    bit moved;
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    n = 0;
    while (digits !== 8'h37 && n < 200) begin step(0, 0, 0, 0); n++; end
    step(0, 1, 0, 0);
    tests_run++;
    if (state !== 2'b10 || digits !== 8'h37) begin
      fails++; $display("FAIL stop got %b/%h required 10/37", state, digits);
    end
    moved = 0;
    repeat (50) begin step(0, 0, 0, 0); if (digits !== 8'h37) moved = 1; end
    tests_run++;
    if (moved) begin fails++; $display("FAIL pause_frozen got %h required 37 throughout", digits); end
    step(1, 0, 0, 0);
    tests_run++;
    if (state !== 2'b01 || digits !== 8'h37) begin
      fails++; $display("FAIL resume got %b/%h required 01/37", state, digits);
    end
    step(0, 0, 0, 0);
    tests_run++;
    if (digits !== 8'h38) begin fails++; $display("FAIL resume_partial got %h required 38", digits); end
  endtask

  task automatic test_lap();
    int n;
    n = 0;
    while (digits !== 8'h42 && n < 200) begin step(0, 0, 0, 0); n++; end
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    tests_run++;
    if (lap_digits !== 8'h42 || digits !== 8'h43 || lap_valid !== 1'b1) begin
      fails++; $display("FAIL lap_on_tick got %h/%h/%b required 42/43/1", lap_digits, digits, lap_valid);
    end
    step(0, 0, 0, 0);
    tests_run++;
    if (lap_valid !== 1'b0 || lap_digits !== 8'h42) begin
      fails++; $display("FAIL lap_pulse got %b/%h required 0/42", lap_valid, lap_digits);
    end
    step(0, 0, 1, 1);
    tests_run++;
    if (lap_valid !== 1'b0 || lap_digits !== 8'h42 || state !== 2'b00) begin
      fails++; $display("FAIL lap_with_clear got %b/%h/%b required 0/42/00", lap_valid, lap_digits, state);
    end
    step(0, 0, 0, 1);
    tests_run++;
    if (lap_valid !== 1'b0 || lap_digits !== 8'h42) begin
      fails++; $display("FAIL lap_idle got %b/%h required 0/42", lap_valid, lap_digits);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1);
      tests_run++;
      if (lap_valid !== 1'b1 || lap_digits !== bcd(m_lap)) begin
        fails++; $display("FAIL lap_held[%0d] got %b/%h required 1/%h", i, lap_valid, lap_digits, bcd(m_lap));
      end
    end
  endtask

  task automatic test_clear_priority();
    repeat (5) step(0, 0, 0, 0);
    step(1, 1, 1, 0);
    tests_run++;
    if (state !== 2'b00 || digits !== 8'h00 || lap_digits !== bcd(m_lap)) begin
      fails++; $display("FAIL clear_prio got %b/%h/%h required 00/00/%h", state, digits, lap_digits, bcd(m_lap));
    end
  endtask

  task automatic test_async_reset();
    int n;
    step(1, 0, 0, 0);
    n = 0;
    while (digits !== 8'h55 && n < 300) begin step(0, 0, 0, 0); n++; end
    tests_run++;
    if (digits !== 8'h55) begin fails++; $display("FAIL reach_55 got %h required 55", digits); end
    #3 reset = 1'b0;
    #1;
    tests_run++;
    if ({state, digits, lap_digits, lap_valid, rollover} !== 20'h0) begin
      fails++; $display("FAIL async_reset got %h required 0", {state, digits, lap_digits, lap_valid, rollover});
    end
    model_reset();
    #2 reset = 1'b1;
    step(0, 0, 0, 0);
    tests_run++;
    if (state !== 2'b00 || digits !== 8'h00) begin
      fails++; $display("FAIL post_reset got %b/%h required 00/00", state, digits);
    end
    step(1, 0, 0, 0);
    tests_run++;
    if (state !== 2'b01) begin fails++; $display("FAIL post_reset_start got %b required 01", state); end
  endtask

  task automatic test_tickdiv1();
    start1 = 1'b1;
    step(0, 0, 0, 0);
    start1 = 1'b0;
    tests_run++;
    if (state1 !== 2'b01 || digits1 !== 8'h00) begin
      fails++; $display("FAIL td1_start got %b/%h required 01/00", state1, digits1);
    end
    for (int k = 1; k <= 12; k++) begin
      step(0, 0, 0, 0);
      tests_run++;
      if (digits1 !== bcd(k)) begin fails++; $display("FAIL td1_count[%0d] got %h required %h", k, digits1, bcd(k)); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 6) == 0,
           $urandom_range(0, 60) == 0, $urandom_range(0, 3) == 0);
      tests_run++;
      if (state !== 2'(m_state) || digits !== bcd(m_cnt)) begin
        fails++; $display("FAIL rnd_count[%0d] got %b/%h required %b/%h", i, state, digits, 2'(m_state), bcd(m_cnt));
      end
      tests_run++;
      if (lap_digits !== bcd(m_lap) || lap_valid !== m_lapv || rollover !== m_roll) begin
        fails++; $display("FAIL rnd_flags[%0d] got %h/%b/%b required %h/%b/%b",
                          i, lap_digits, lap_valid, rollover, bcd(m_lap), m_lapv, m_roll);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_count();
    test_rollover();
    test_pause();
    test_lap();
    test_back_to_back();
    test_clear_priority();
    test_async_reset();
    test_tickdiv1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
